// File: rtl/and4_sweep_controller_if.sv
// Signal bundle between the AND4 sweep controller and its environment: sweep control,
// the four datapath drives, the datapath result and the sweep status.
interface and4_sweep_controller_if #(
  parameter int unsigned ERR_W = 5
);
  logic             start;
  logic             abort;
  logic             dut_y;
  logic             dut_a;
  logic             dut_b;
  logic             dut_c;
  logic             dut_d;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;

  // Environment side: issues commands, returns the datapath output.
  modport master (
    output start, abort, dut_y,
    input  dut_a, dut_b, dut_c, dut_d, busy, done, pass, err_count
  );

  // Controller side.
  modport slave (
    input  start, abort, dut_y,
    output dut_a, dut_b, dut_c, dut_d, busy, done, pass, err_count
  );
endinterface

// File: rtl/and4_sweep_controller.sv
// Sweeps all 16 {a,b,c,d} patterns through a pipelined AND4 datapath, checks each result
// after the datapath latency and reports a saturating mismatch count plus pass/done.
module and4_sweep_controller #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned PASSES  = 1,
  parameter int unsigned ERR_W   = 5
) (
  input logic                   clk,
  input logic                   rst,
  and4_sweep_controller_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StApply, StWait, StCheck, StDone} state_e;

  localparam logic [3:0] LatLoad  = 4'(LATENCY - 1);
  localparam logic [3:0] LastPass = 4'(PASSES - 1);

  state_e           r_state, w_state_d;
  logic [3:0]       r_pattern, w_pattern_d;
  logic [3:0]       r_pass_cnt, w_pass_cnt_d;
  logic [3:0]       r_wait, w_wait_d;
  logic [ERR_W-1:0] r_err, w_err_d;
  logic [3:0]       r_dut;
  logic             r_busy, r_done, r_pass;
  logic             w_busy_d;

  always_comb begin
    w_state_d    = r_state;
    w_pattern_d  = r_pattern;
    w_pass_cnt_d = r_pass_cnt;
    w_wait_d     = r_wait;
    w_err_d      = r_err;
    unique case (r_state)
      StIdle, StDone: begin
        if (bus.start) begin
          w_err_d      = '0;
          w_pattern_d  = '0;
          w_pass_cnt_d = '0;
          w_state_d    = StApply;
        end
      end
      StApply: begin
        if (bus.abort) begin
          w_state_d = StIdle;
        end else if (LATENCY > 0) begin
          w_wait_d  = LatLoad;
          w_state_d = StWait;
        end else begin
          w_state_d = StCheck;
        end
      end
      StWait: begin
        if (bus.abort) begin
          w_state_d = StIdle;
        end else if (r_wait == 4'd0) begin
          w_state_d = StCheck;
        end else begin
          w_wait_d = r_wait - 4'd1;
        end
      end
      StCheck: begin
        // Abort takes priority: the pattern under check is discarded, not scored.
        if (bus.abort) begin
          w_state_d = StIdle;
        end else begin
          if ((bus.dut_y != (&r_pattern)) && (r_err != '1)) begin
            w_err_d = r_err + ERR_W'(1);
          end
          if (r_pattern != 4'hF) begin
            w_pattern_d = r_pattern + 4'd1;
            w_state_d   = StApply;
          end else if (r_pass_cnt != LastPass) begin
            w_pass_cnt_d = r_pass_cnt + 4'd1;
            w_pattern_d  = '0;
            w_state_d    = StApply;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_busy_d = (w_state_d == StApply) || (w_state_d == StWait) || (w_state_d == StCheck);

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_pattern  <= '0;
      r_pass_cnt <= '0;
      r_wait     <= '0;
      r_err      <= '0;
      r_dut      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pattern  <= w_pattern_d;
      r_pass_cnt <= w_pass_cnt_d;
      r_wait     <= w_wait_d;
      r_err      <= w_err_d;
      r_dut      <= w_busy_d ? w_pattern_d : 4'd0;
      r_busy     <= w_busy_d;
      r_done     <= (w_state_d == StDone);
      r_pass     <= (w_state_d == StDone) && (w_err_d == '0);
    end
  end

  assign bus.dut_a     = r_dut[3];
  assign bus.dut_b     = r_dut[2];
  assign bus.dut_c     = r_dut[1];
  assign bus.dut_d     = r_dut[0];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;

endmodule

// File: tb/tb_and4_sweep_controller.sv
// Scoreboard bench: two controllers (LATENCY=2/PASSES=1/ERR_W=5 and LATENCY=0/PASSES=2/ERR_W=3)
// drive behavioural AND4 datapaths with selectable faults; a monitor scores each sweep end.
module tb_and4_sweep_controller;

  localparam int unsigned LatA = 2;
  localparam int unsigned LatB = 0;

  typedef struct {
    string name;
    int    done;
    int    pass;
    int    err;
    int    cyc;
  } exp_t;

  logic clk;
  logic rst;

  and4_sweep_controller_if #(.ERR_W(5)) bus_a ();
  and4_sweep_controller_if #(.ERR_W(3)) bus_b ();

  and4_sweep_controller #(.LATENCY(LatA), .PASSES(1), .ERR_W(5)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  and4_sweep_controller #(.LATENCY(LatB), .PASSES(2), .ERR_W(3)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Datapath models. fault: 0 good, 1 stuck-0, 2 stuck-1, 3 flip at one pattern.
  logic [1:0] fault_a = 2'd0;
  logic [1:0] fault_b = 2'd0;
  logic [3:0] inj_a   = 4'd0;
  logic [3:0] pat_a, pat_b;
  logic       y1_a, y2_a;

  assign pat_a = {bus_a.dut_a, bus_a.dut_b, bus_a.dut_c, bus_a.dut_d};
  assign pat_b = {bus_b.dut_a, bus_b.dut_b, bus_b.dut_c, bus_b.dut_d};

  always_ff @(posedge clk) begin
    y1_a <= &pat_a;
    y2_a <= y1_a;
  end

  always_comb begin
    bus_a.dut_y = y2_a;
    case (fault_a)
      2'd1:    bus_a.dut_y = 1'b0;
      2'd2:    bus_a.dut_y = 1'b1;
      2'd3:    bus_a.dut_y = y2_a ^ (pat_a == inj_a);
      default: bus_a.dut_y = y2_a;
    endcase
  end

  always_comb begin
    bus_b.dut_y = &pat_b;
    case (fault_b)
      2'd1:    bus_b.dut_y = 1'b0;
      2'd2:    bus_b.dut_y = 1'b1;
      default: bus_b.dut_y = &pat_b;
    endcase
  end

  // Scoreboard queues, filled by the stimulus when a sweep is launched.
  exp_t q_a[$];
  exp_t q_b[$];

  task automatic push_a(input string n, input int d, input int p, input int e, input int c);
    exp_t x;
    x.name = n; x.done = d; x.pass = p; x.err = e; x.cyc = c;
    q_a.push_back(x);
  endtask

  task automatic push_b(input string n, input int d, input int p, input int e, input int c);
    exp_t x;
    x.name = n; x.done = d; x.pass = p; x.err = e; x.cyc = c;
    q_b.push_back(x);
  endtask

  // Monitors: track the pattern walk while busy; score the sweep when busy falls.
  logic busy_prev_a = 1'b0;
  logic busy_prev_b = 1'b0;
  int   cyc_a = 0, seqerr_a = 0;
  int   cyc_b = 0, seqerr_b = 0;

  always @(negedge clk) begin
    exp_t e;
    if (bus_a.busy) begin
      if (!busy_prev_a) begin
        cyc_a    = 0;
        seqerr_a = 0;
      end
      if (pat_a != 4'((cyc_a / (LatA + 2)) % 16)) seqerr_a++;
      cyc_a++;
    end else if (busy_prev_a) begin
      if (q_a.size() == 0) begin
        check("sb_a_underflow", 1, 0);
      end else begin
        e = q_a.pop_front();
        check({e.name, "_done"}, int'(bus_a.done), e.done);
        check({e.name, "_pass"}, int'(bus_a.pass), e.pass);
        check({e.name, "_err"}, int'(bus_a.err_count), e.err);
        check({e.name, "_cycles"}, cyc_a, e.cyc);
        check({e.name, "_seq"}, seqerr_a, 0);
        check({e.name, "_dut_idle"}, int'(pat_a), 0);
      end
    end
    busy_prev_a = bus_a.busy;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_b.busy) begin
      if (!busy_prev_b) begin
        cyc_b    = 0;
        seqerr_b = 0;
      end
      if (pat_b != 4'((cyc_b / (LatB + 2)) % 16)) seqerr_b++;
      cyc_b++;
    end else if (busy_prev_b) begin
      if (q_b.size() == 0) begin
        check("sb_b_underflow", 1, 0);
      end else begin
        e = q_b.pop_front();
        check({e.name, "_done"}, int'(bus_b.done), e.done);
        check({e.name, "_pass"}, int'(bus_b.pass), e.pass);
        check({e.name, "_err"}, int'(bus_b.err_count), e.err);
        check({e.name, "_cycles"}, cyc_b, e.cyc);
        check({e.name, "_seq"}, seqerr_b, 0);
        check({e.name, "_dut_idle"}, int'(pat_b), 0);
      end
    end
    busy_prev_b = bus_b.busy;
  end

  // Called at a negedge; start is sampled at the next posedge.
  task automatic pulse_a(input string n);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    check({n, "_busy_rise"}, int'(bus_a.busy), 1);
  endtask

  task automatic pulse_b(input string n);
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    check({n, "_busy_rise"}, int'(bus_b.busy), 1);
  endtask

  task automatic wait_a(input string n, input int budget);
    int k = 0;
    while (bus_a.busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (bus_a.busy) check({n, "_timeout"}, 1, 0);
  endtask

  task automatic wait_b(input string n, input int budget);
    int k = 0;
    while (bus_b.busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (bus_b.busy) check({n, "_timeout"}, 1, 0);
  endtask

  initial begin
    rst         = 1'b1;
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_b.start = 1'b0;
    bus_b.abort = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_a_dut", int'(pat_a), 0);
    check("rst_a_busy", int'(bus_a.busy), 0);
    check("rst_a_done", int'(bus_a.done), 0);
    check("rst_a_pass", int'(bus_a.pass), 0);
    check("rst_a_err", int'(bus_a.err_count), 0);
    check("rst_b_busy", int'(bus_b.busy), 0);
    check("rst_b_done", int'(bus_b.done), 0);
    check("rst_b_err", int'(bus_b.err_count), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Good datapath: 16 patterns x 4 cycles.
    push_a("t1_good", 1, 1, 0, 64);
    pulse_a("t1");
    wait_a("t1", 200);

    // Stuck-at-0, launched from DONE with abort also high (start wins there).
    fault_a     = 2'd1;
    push_a("t2_stuck0", 1, 0, 1, 64);
    bus_a.abort = 1'b1;
    pulse_a("t2");
    check("t2_done_drop", int'(bus_a.done), 0);
    wait_a("t2", 200);

    // One injected mismatch at pattern 2, abort at the CHECK of pattern 5.
    fault_a = 2'd3;
    inj_a   = 4'd2;
    push_a("t5_abort", 0, 0, 1, 24);
    pulse_a("t5");
    repeat (23) @(negedge clk);
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    check("t5_abort_busy", int'(bus_a.busy), 0);
    check("t5_abort_done", int'(bus_a.done), 0);
    check("t5_abort_err", int'(bus_a.err_count), 1);
    check("t5_abort_dut", int'(pat_a), 0);
    fault_a = 2'd0;
    push_a("t5_restart", 1, 1, 0, 64);
    pulse_a("t5b");
    check("t5b_err_cleared", int'(bus_a.err_count), 0);
    wait_a("t5b", 200);

    // Start held high through the sweep; reset during WAIT of pattern 9.
    push_a("t6_rst", 0, 0, 0, 37);
    bus_a.start = 1'b1;
    @(negedge clk);
    check("t6_busy_rise", int'(bus_a.busy), 1);
    repeat (37) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("t6_rst_dut", int'(pat_a), 0);
    check("t6_rst_busy", int'(bus_a.busy), 0);
    check("t6_rst_done", int'(bus_a.done), 0);
    check("t6_rst_pass", int'(bus_a.pass), 0);
    check("t6_rst_err", int'(bus_a.err_count), 0);
    bus_a.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_stays_idle", int'(bus_a.busy), 0);

    // LATENCY=0, two passes: 2 cycles per pattern, 64 total.
    push_b("t4_two_pass", 1, 1, 0, 64);
    pulse_b("t4");
    wait_b("t4", 200);

    // Stuck-at-1: 30 mismatches saturate a 3-bit counter at 7.
    fault_b = 2'd2;
    push_b("t3_sat", 1, 0, 7, 64);
    pulse_b("t3");
    check("t3_done_drop", int'(bus_b.done), 0);
    check("t3_err_cleared", int'(bus_b.err_count), 0);
    wait_b("t3", 200);

    repeat (3) @(negedge clk);
    check("sb_drained", q_a.size() + q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
